// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller register window.
// Offsets are word indices (CPU address bits [3:2]).
package irq_pkg;

    localparam int IRQ_N_SRC_DEFAULT = 6;

    localparam logic [1:0] IRQ_OFF_PEND   = 2'd0;
    localparam logic [1:0] IRQ_OFF_MASK   = 2'd1;
    localparam logic [1:0] IRQ_OFF_MODE   = 2'd2;
    localparam logic [1:0] IRQ_OFF_ACTIVE = 2'd3;

    localparam int IRQ_ACTIVE_ANY_BIT = 31;

endpackage

// File: rtl/irq_sync.sv
// Source synchroniser and rising-edge detector.
// IRQ_SYNC_EN selects a two-flop synchroniser; otherwise src is used as-is.
module irq_sync
    import irq_pkg::*;
#(
    parameter int N_SRC = IRQ_N_SRC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    output logic [N_SRC-1:0] level,
    output logic [N_SRC-1:0] rise
);

    logic [N_SRC-1:0] prev;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] s1;
    logic [N_SRC-1:0] s2;

    // Two-flop synchroniser for the asynchronous source lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= src;
            s2 <= s1;
        end
    end

    assign level = s2;
`else
    assign level = src;
`endif

    // Previous level, so a rise lasts exactly one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: PEND/MASK/MODE registers, W1C, ACTIVE encoder.
// Build with IRQ_SYNC_EN defined to synchronise src through two flops.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_SRC = IRQ_N_SRC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             write_enable,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_result,
    input  logic [N_SRC-1:0] src,
    output logic [N_SRC-1:0] irq_out
);

    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] level;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] wr_bits;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] active_oh;
    logic             wr_en;
    logic             wd_unused;

    irq_sync #(
        .N_SRC(N_SRC)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .src  (src),
        .level(level),
        .rise (rise)
    );

    assign wr_en     = sel & write_enable;
    assign wr_bits   = write_data[N_SRC-1:0];
    assign wd_unused = ^write_data;
    assign clr       = (wr_en && addr == IRQ_OFF_PEND) ? wr_bits : '0;

    // Edge bits: a new rise beats a same-cycle clear. Level bits track the line.
    assign pend_nxt = (mode & ((pend & ~clr) | rise)) | (~mode & level);

    assign req = pend & mask;

    // Register state and the registered interrupt outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= '0;
            mask    <= '0;
            mode    <= '0;
            irq_out <= '0;
        end else begin
            pend    <= pend_nxt;
            irq_out <= req;
            if (wr_en && addr == IRQ_OFF_MASK) begin
                mask <= wr_bits;
            end
            if (wr_en && addr == IRQ_OFF_MODE) begin
                mode <= wr_bits;
            end
        end
    end

    // Lowest-index masked pending source, one-hot
    always_comb begin
        active_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                active_oh    = '0;
                active_oh[i] = 1'b1;
            end
        end
    end

    // Register read mux; zero when the window is not selected
    always_comb begin
        read_result = '0;
        if (sel) begin
            case (addr)
                IRQ_OFF_PEND:   read_result[N_SRC-1:0] = pend;
                IRQ_OFF_MASK:   read_result[N_SRC-1:0] = mask;
                IRQ_OFF_MODE:   read_result[N_SRC-1:0] = mode;
                IRQ_OFF_ACTIVE: begin
                    read_result[N_SRC-1:0]            = active_oh;
                    read_result[IRQ_ACTIVE_ANY_BIT]   = |req;
                end
                default:        read_result = '0;
            endcase
        end
    end

endmodule
